// File: rtl/fpm_booth8_pkg.sv
// Shared constants, digit type and radix-8 Booth digit encoder for the
// FP multiplier partial-product generator.
package fpm_booth8_pkg;

   localparam int MANT_W = 24;
   localparam int NPP    = (MANT_W + 3) / 3;
   localparam int PP_W   = MANT_W + 2;

   // One radix-8 Booth digit: sign plus magnitude 0..4.
   typedef struct packed {
      logic       neg;
      logic [2:0] mag;
   } booth_digit_t;

   // Window {b3,b2,b1,b0} -> d = -4*b3 + 2*b2 + b1 + b0.
   // 1111 is deliberately encoded as +0 so that no row ever carries a
   // negative zero (which would otherwise inject a spurious +1).
   function automatic booth_digit_t booth8_encode(input logic [3:0] win);
      booth_digit_t dig;
      dig.neg = win[3] & ~(win[2] & win[1] & win[0]);
      case (win)
         4'b0001, 4'b0010, 4'b1101, 4'b1110: dig.mag = 3'd1;
         4'b0011, 4'b0100, 4'b1011, 4'b1100: dig.mag = 3'd2;
         4'b0101, 4'b0110, 4'b1001, 4'b1010: dig.mag = 3'd3;
         4'b0111, 4'b1000:                   dig.mag = 3'd4;
         default:                            dig.mag = 3'd0;
      endcase
      return dig;
   endfunction

endpackage

// File: rtl/booth8_row_sel.sv
// Selects one partial-product row from a Booth digit: 0, M, 2M, 3M or 4M,
// inverted when the digit is negative. The +1 of the two's complement
// negation is left to the consumer via neg_o.
module booth8_row_sel
   import fpm_booth8_pkg::*;
#(
   parameter int MANT_W = fpm_booth8_pkg::MANT_W,
   parameter int PP_W   = fpm_booth8_pkg::PP_W
) (
   input  booth_digit_t      digit_i,
   input  logic [MANT_W-1:0] mcand_i,
   input  logic [PP_W-1:0]   m3_i,
   output logic [PP_W-1:0]   row_o,
   output logic              neg_o
);

   logic [PP_W-1:0] m_ext;
   logic [PP_W-1:0] mag;

   assign m_ext = {{(PP_W-MANT_W){1'b0}}, mcand_i};

   // Magnitude multiplexer over the precomputed multiples.
   always_comb begin
      mag = '0;
      case (digit_i.mag)
         3'd1:    mag = m_ext;
         3'd2:    mag = m_ext << 1;
         3'd3:    mag = m3_i;
         3'd4:    mag = m_ext << 2;
         default: mag = '0;
      endcase
   end

   assign row_o = digit_i.neg ? ~mag : mag;
   assign neg_o = digit_i.neg;

endmodule

// File: rtl/booth8_pp_gen.sv
// Radix-8 Booth partial-product generator with an elastic valid/ready pipe.
// S1 captures M, Y, tag and the hard multiple 3M; S2 encodes the digits and
// registers the NPP rows, their negate bits and the tag.
// Build option FPM_BOOTH_3M_SPLIT_EN: splits the 3M adder into a low half
// (S1a) and a high half (S1b), adding one cycle of latency.
module booth8_pp_gen
   import fpm_booth8_pkg::*;
#(
   parameter int MANT_W = fpm_booth8_pkg::MANT_W,
   parameter int NPP    = fpm_booth8_pkg::NPP,
   parameter int PP_W   = fpm_booth8_pkg::PP_W,
   parameter int TAG_W  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [MANT_W-1:0]   in_mcand,
   input  logic [MANT_W-1:0]   in_mplier,
   input  logic [TAG_W-1:0]    in_tag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [NPP*PP_W-1:0] out_pp,
   output logic [NPP-1:0]      out_neg,
   output logic [TAG_W-1:0]    out_tag
);

   if (NPP != (MANT_W + 3) / 3) begin : g_npp_chk
      $error("booth8_pp_gen: NPP must equal (MANT_W+3)/3");
   end
   if (PP_W != MANT_W + 2) begin : g_ppw_chk
      $error("booth8_pp_gen: PP_W must equal MANT_W+2");
   end

   // Stage feeding S2 (S1, or S1b in the split build).
   logic                s1_valid_q, s1_valid_d;
   logic [MANT_W-1:0]   s1_m_q;
   logic [MANT_W-1:0]   s1_y_q;
   logic [TAG_W-1:0]    s1_tag_q;
   logic [PP_W-1:0]     s1_m3_q, s1_m3_d;

   logic                out_valid_q, out_valid_d;
   logic [NPP*PP_W-1:0] out_pp_q, out_pp_d;
   logic [NPP-1:0]      out_neg_q, out_neg_d;
   logic [TAG_W-1:0]    out_tag_q;

   logic                s2_free;
   logic                s2_load;
   logic                in_fire;

   assign s2_free = !out_valid_q || out_ready;
   assign s2_load = s1_valid_q && s2_free;

`ifdef FPM_BOOTH_3M_SPLIT_EN
   localparam int LO_W = (PP_W + 1) / 2;
   localparam int LO_C = LO_W + 1;
   localparam int HI_W = PP_W - LO_W;

   logic              s1a_valid_q, s1a_valid_d;
   logic [MANT_W-1:0] s1a_m_q;
   logic [MANT_W-1:0] s1a_y_q;
   logic [TAG_W-1:0]  s1a_tag_q;
   logic [LO_W:0]     s1a_lo_q, s1a_lo_d;
   logic [HI_W-1:0]   s1b_hi;
   logic              s1_free;
   logic              s1a_adv;

   assign s1_free     = !s1_valid_q || s2_free;
   assign s1a_adv     = s1a_valid_q && s1_free;
   assign in_ready    = !s1a_valid_q || s1_free;
   assign in_fire     = in_valid && in_ready;
   assign s1a_valid_d = in_ready ? in_valid : s1a_valid_q;
   assign s1_valid_d  = s1_free ? s1a_valid_q : s1_valid_q;

   // Low half of M + 2M, keeping the carry into the high half.
   assign s1a_lo_d = LO_C'(in_mcand[LO_W-1:0]) + LO_C'({in_mcand[LO_W-2:0], 1'b0});
   // High half of M + 2M plus the carry captured in S1a.
   assign s1b_hi   = HI_W'(s1a_m_q >> LO_W) + HI_W'(s1a_m_q >> (LO_W - 1))
                   + HI_W'(s1a_lo_q[LO_W]);
   assign s1_m3_d  = {s1b_hi, s1a_lo_q[LO_W-1:0]};

   // Valid flags of S1a and S1b.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1a_valid_q <= 1'b0;
         s1_valid_q  <= 1'b0;
      end else begin
         s1a_valid_q <= s1a_valid_d;
         s1_valid_q  <= s1_valid_d;
      end
   end

   // Operand capture in S1a and hand-over to S1b with the finished 3M.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         s1a_m_q   <= in_mcand;
         s1a_y_q   <= in_mplier;
         s1a_tag_q <= in_tag;
         s1a_lo_q  <= s1a_lo_d;
      end
      if (s1a_adv) begin
         s1_m_q   <= s1a_m_q;
         s1_y_q   <= s1a_y_q;
         s1_tag_q <= s1a_tag_q;
         s1_m3_q  <= s1_m3_d;
      end
   end
`else
   logic [PP_W-1:0] in_m_ext;

   assign in_ready   = !s1_valid_q || s2_free;
   assign in_fire    = in_valid && in_ready;
   assign s1_valid_d = in_ready ? in_valid : s1_valid_q;
   assign in_m_ext   = {{(PP_W-MANT_W){1'b0}}, in_mcand};
   assign s1_m3_d    = in_m_ext + (in_m_ext << 1);

   // S1 valid flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
      end
   end

   // Operand capture and single-cycle 3M.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         s1_m_q   <= in_mcand;
         s1_y_q   <= in_mplier;
         s1_tag_q <= in_tag;
         s1_m3_q  <= s1_m3_d;
      end
   end
`endif

   // Digit windows overlap by one bit; the extra top zeros keep the last
   // digit at 0 or +1 because Y is unsigned.
   logic [MANT_W+3:0] y_ext;
   booth_digit_t      digit [NPP];

   assign y_ext = {3'b000, s1_y_q, 1'b0};

   for (genvar i = 0; i < NPP; i++) begin : g_row
      assign digit[i] = booth8_encode(y_ext[3*i +: 4]);

      booth8_row_sel #(
         .MANT_W (MANT_W),
         .PP_W   (PP_W)
      ) u_row_sel (
         .digit_i (digit[i]),
         .mcand_i (s1_m_q),
         .m3_i    (s1_m3_q),
         .row_o   (out_pp_d[i*PP_W +: PP_W]),
         .neg_o   (out_neg_d[i])
      );
   end

   assign out_valid_d = s2_free ? s1_valid_q : out_valid_q;

   // Output stage: loads only when it can hand over, so data holds during stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_pp_q    <= '0;
         out_neg_q   <= '0;
         out_tag_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         if (s2_load) begin
            out_pp_q  <= out_pp_d;
            out_neg_q <= out_neg_d;
            out_tag_q <= s1_tag_q;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_pp    = out_pp_q;
   assign out_neg   = out_neg_q;
   assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_booth8_pp_gen.sv
// Bench for booth8_pp_gen: directed vectors with literal expectations, a
// digit-arithmetic reference model and a scoreboard checked on every cycle
// that out_valid is high.
module tb_booth8_pp_gen;

   localparam int MW  = 24;
   localparam int N   = 9;
   localparam int PPW = 26;
   localparam int TW  = 4;
`ifdef FPM_BOOTH_3M_SPLIT_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [MW-1:0]    in_mcand;
   logic [MW-1:0]    in_mplier;
   logic [TW-1:0]    in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [N*PPW-1:0] out_pp;
   logic [N-1:0]     out_neg;
   logic [TW-1:0]    out_tag;

   booth8_pp_gen dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mcand  (in_mcand),
      .in_mplier (in_mplier),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pp    (out_pp),
      .out_neg   (out_neg),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int n_out = 0;

   typedef struct {
      logic [MW-1:0] m;
      logic [MW-1:0] y;
      logic [TW-1:0] t;
   } pair_t;
   pair_t sb[$];

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, got, exp);
      end
   endtask

   // Booth digit value straight from the arithmetic definition.
   function automatic int digit_val(input logic [MW-1:0] y, input int i);
      logic [MW+3:0] ye;
      logic [3:0]    w;
      ye = {3'b000, y, 1'b0};
      w  = ye[3*i +: 4];
      return -4 * int'(w[3]) + 2 * int'(w[2]) + int'(w[1]) + int'(w[0]);
   endfunction

   function automatic logic [N*PPW-1:0] model_pp(input logic [MW-1:0] m, input logic [MW-1:0] y);
      logic [N*PPW-1:0] v;
      logic [63:0]      mag;
      int               d;
      v = '0;
      for (int i = 0; i < N; i++) begin
         d   = digit_val(y, i);
         mag = 64'(d < 0 ? -d : d) * 64'(m);
         if (d < 0) mag = ~mag;
         v[i*PPW +: PPW] = mag[PPW-1:0];
      end
      return v;
   endfunction

   function automatic logic [N-1:0] model_neg(input logic [MW-1:0] y);
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = (digit_val(y, i) < 0);
      return v;
   endfunction

   // Sum of sign-extended rows plus negate bits, weighted 8^i, mod 2^48.
   function automatic logic [63:0] recon(input logic [N*PPW-1:0] pp, input logic [N-1:0] ng);
      logic [63:0] acc;
      logic [63:0] r;
      acc = '0;
      for (int i = 0; i < N; i++) begin
         r = 64'(pp[i*PPW +: PPW]);
         if (ng[i]) r = r - (64'd1 << PPW) + 64'd1;
         acc = acc + (r << (3*i));
      end
      return acc & 64'h0000_FFFF_FFFF_FFFF;
   endfunction

   // Scoreboard: compare every presented output, check stability under stall.
   logic             prev_stall = 1'b0;
   logic [N*PPW-1:0] prev_pp;
   logic [N-1:0]     prev_neg;
   logic [TW-1:0]    prev_tag;

   always @(negedge clk) begin
      pair_t e;
      if (rst) begin
         sb.delete();
         prev_stall = 1'b0;
      end else begin
         if (out_valid) begin
            if (sb.size() == 0) begin
               chk("out_valid_with_nothing_in_flight", 256'(out_valid), 256'd0);
            end else begin
               e = sb[0];
               chk("sb_pp",  256'(out_pp),  256'(model_pp(e.m, e.y)));
               chk("sb_neg", 256'(out_neg), 256'(model_neg(e.y)));
               chk("sb_tag", 256'(out_tag), 256'(e.t));
               chk("sb_sum", 256'(recon(out_pp, out_neg)), 256'(64'(e.m) * 64'(e.y)));
            end
            if (prev_stall) begin
               chk("stall_hold_pp",  256'(out_pp),  256'(prev_pp));
               chk("stall_hold_neg", 256'(out_neg), 256'(prev_neg));
               chk("stall_hold_tag", 256'(out_tag), 256'(prev_tag));
            end
         end
         if (out_valid && out_ready && sb.size() > 0) begin
            void'(sb.pop_front());
            n_out++;
         end
         if (in_valid && in_ready) begin
            e.m = in_mcand;
            e.y = in_mplier;
            e.t = in_tag;
            sb.push_back(e);
         end
         prev_stall = out_valid && !out_ready;
         prev_pp    = out_pp;
         prev_neg   = out_neg;
         prev_tag   = out_tag;
      end
   end

   // Present a pair and wait (bounded) for its acceptance; returns after the
   // accepting edge. waits counts cycles lost to in_ready low.
   task automatic send(input logic [MW-1:0] m, input logic [MW-1:0] y, input logic [TW-1:0] t,
                       input bit hold, output int waits);
      bit fire;
      in_valid  = 1'b1;
      in_mcand  = m;
      in_mplier = y;
      in_tag    = t;
      waits     = 0;
      fire      = 1'b0;
      while (!fire && waits < 50) begin
         @(negedge clk);
         fire = in_ready;
         @(posedge clk);
         #1;
         if (!fire) waits++;
      end
      if (!fire) chk("accept_timeout", 256'(in_ready), 256'd1);
      if (!hold) in_valid = 1'b0;
   endtask

   // Latency counted in edges from the accepting edge (inclusive).
   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int c;
      c = 0;
      while ((sb.size() != 0 || out_valid) && c < 60) begin
         step(1);
         c++;
      end
      chk("drain_sb_empty", 256'(sb.size()), 256'd0);
   endtask

   initial begin
      int lat;
      int w;
      int base;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_mcand  = '0;
      in_mplier = '0;
      in_tag    = '0;
      out_ready = 1'b1;
      step(3);
      rst = 1'b0;
      step(1);
      chk("rst_in_ready",  256'(in_ready),  256'd1);
      chk("rst_out_valid", 256'(out_valid), 256'd0);
      chk("rst_out_pp",    256'(out_pp),    256'd0);
      chk("rst_out_neg",   256'(out_neg),   256'd0);
      chk("rst_out_tag",   256'(out_tag),   256'd0);

      // All-ones operands: only digit 0 (-1) and digit 8 (+1) are nonzero.
      send(24'hFFFFFF, 24'hFFFFFF, 4'h1, 1'b0, w);
      wait_out(lat);
      chk("ones_latency", 256'(lat), 256'(LAT));
      chk("ones_neg",  256'(out_neg), 256'h001);
      chk("ones_row0", 256'(out_pp[0 +: PPW]), 256'h3000000);
      chk("ones_rows1_7", 256'(out_pp[PPW +: 7*PPW]), 256'd0);
      chk("ones_row8", 256'(out_pp[8*PPW +: PPW]), 256'h0FFFFFF);
      chk("ones_sum",  256'(recon(out_pp, out_neg)), 256'h0000FFFFFE000001);
      step(1);

      // Y=7: window0 1110 (-1), window1 0001 (+1).
      send(24'h800000, 24'h000007, 4'h2, 1'b0, w);
      wait_out(lat);
      chk("y7_row0", 256'(out_pp[0 +: PPW]), 256'h37FFFFF);
      chk("y7_neg0", 256'(out_neg[0]), 256'd1);
      chk("y7_row1", 256'(out_pp[PPW +: PPW]), 256'h0800000);
      chk("y7_sum",  256'(recon(out_pp, out_neg)), 256'h3800000);
      step(1);

      // Y=3: window0 0110 (+3) selects the hard multiple.
      send(24'h800000, 24'h000003, 4'h3, 1'b0, w);
      wait_out(lat);
      chk("y3_row0", 256'(out_pp[0 +: PPW]), 256'h1800000);
      chk("y3_neg",  256'(out_neg), 256'd0);
      chk("y3_sum",  256'(recon(out_pp, out_neg)), 256'h1800000);
      step(1);

      // Y=4: window0 1000 (-4), window1 0001 (+1).
      send(24'h123456, 24'h000004, 4'h4, 1'b0, w);
      wait_out(lat);
      chk("y4_row0", 256'(out_pp[0 +: PPW]), 256'h3B72EA7);
      chk("y4_neg",  256'(out_neg), 256'h001);
      chk("y4_row1", 256'(out_pp[PPW +: PPW]), 256'h0123456);
      chk("y4_sum",  256'(recon(out_pp, out_neg)), 256'h48D158);
      step(1);

      // Zero multiplicand: magnitudes zero, negate bits still follow Y.
      send(24'h000000, 24'hFFFFFF, 4'h5, 1'b0, w);
      wait_out(lat);
      chk("m0_neg", 256'(out_neg), 256'h001);
      chk("m0_sum", 256'(recon(out_pp, out_neg)), 256'd0);
      step(1);

      // Backpressure: 8 random pairs with out_ready toggling 1,0,1,0...
      base = n_out;
      fork
         begin
            for (int k = 0; k < 8; k++) begin
               send(24'($urandom_range(24'hFFFFFF, 0)), 24'($urandom_range(24'hFFFFFF, 0)),
                    4'(k), (k < 7), w);
            end
         end
         begin
            for (int c = 0; c < 60; c++) begin
               out_ready = (c % 2 == 0);
               step(1);
            end
            out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_count", 256'(n_out - base), 256'd8);

      // Reset with two pairs in flight.
      out_ready = 1'b0;
      send(24'h0ABCDE, 24'h13579B, 4'h9, 1'b1, w);
      send(24'h555555, 24'hAAAAAA, 4'hA, 1'b0, w);
      rst = 1'b1;
      step(1);
      chk("midrst_out_valid", 256'(out_valid), 256'd0);
      rst = 1'b0;
      chk("midrst_in_ready", 256'(in_ready), 256'd1);
      out_ready = 1'b1;
      base = n_out;
      send(24'hC0FFEE, 24'h0BEEF1, 4'hB, 1'b0, w);
      wait_out(lat);
      chk("midrst_latency", 256'(lat), 256'(LAT));
      chk("midrst_tag", 256'(out_tag), 256'hB);
      drain();
      chk("midrst_count", 256'(n_out - base), 256'd1);

      // Back-to-back throughput with the sink always ready.
      base = n_out;
      for (int k = 0; k < 4; k++) begin
         send(24'(24'h100001 * (k + 1)), 24'(24'h0F0F0F + k), 4'(12 + k), (k < 3), w);
         chk("b2b_waits", 256'(w), 256'd0);
      end
      drain();
      chk("b2b_count", 256'(n_out - base), 256'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
